// File: rtl/meter_pkg.sv
// Constants shared by the meter front-end and the main billing block.
// Pure definitions: no logic, no latency, no flow control.
package meter_pkg;

  localparam int UNIT_W    = 10;
  localparam int UNITS_MAX = 1023;

  localparam int DEF_PULSES_PER_UNIT = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 3;
  localparam int DEF_CYCLES_PER_DAY  = 100;
  localparam int DEF_MIN_PULSE_GAP   = 2;

  typedef logic [UNIT_W-1:0] units_t;

  // Bits needed to hold the values 0..maxval.
  function automatic int cnt_w(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/meter_debounce.sv
// Two-flop synchronizer plus run-length debouncer; emits a one-cycle pulse_accept per 0->1 level flip.
// Latency: first high sample at edge k -> pulse_accept registered at edge k+2+DEBOUNCE_CYCLES; no backpressure.
module meter_debounce
  import meter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  output logic pulse_accept
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          rise;
  logic [CW-1:0] run_cnt;
  logic          flip;

  // The current sample is the last of a full run that disagrees with the stable level.
  assign flip = (sync2 != stable) && (run_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      stable       <= 1'b0;
      run_cnt      <= '0;
      rise         <= 1'b0;
      pulse_accept <= 1'b0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        run_cnt <= '0;
      end else if (flip) begin
        run_cnt <= '0;
        stable  <= sync2;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
      rise         <= flip & sync2;
      pulse_accept <= rise;
    end
  end

endmodule

// File: rtl/meter_pulse_frontend.sv
// Meter front-end: debounced pulses -> unit strobes (sensor), day strobes (date_1), unit total, tamper flag.
// Latency: sensor one cycle after pulse_accept; no backpressure. Optional gap check under METER_TAMPER_DETECT_EN.
module meter_pulse_frontend
  import meter_pkg::*;
#(
  parameter int PULSES_PER_UNIT = DEF_PULSES_PER_UNIT,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CYCLES_PER_DAY  = DEF_CYCLES_PER_DAY,
  parameter int MIN_PULSE_GAP   = DEF_MIN_PULSE_GAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sensor_raw,
  input  logic              enable,
  output logic              sensor,
  output logic              date_1,
  output logic [UNIT_W-1:0] units_total,
  output logic              tamper
);

  localparam int PW = cnt_w(PULSES_PER_UNIT - 1);
  localparam int DW = cnt_w(CYCLES_PER_DAY - 1);

  logic          pulse_accept;
  logic          pulse_ok;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] dcnt;
  logic          unit_done;
  logic          day_done;

  meter_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .sensor_raw  (sensor_raw),
    .pulse_accept(pulse_accept)
  );

`ifdef METER_TAMPER_DETECT_EN
  localparam int GW = cnt_w(MIN_PULSE_GAP);

  logic [GW-1:0] gap_cnt;
  logic          too_close;

  // gap_cnt equals the edge distance to the previous accepted pulse, saturating at MIN_PULSE_GAP.
  assign too_close = pulse_accept && (gap_cnt < GW'(MIN_PULSE_GAP));

  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_cnt <= GW'(MIN_PULSE_GAP);
      tamper  <= 1'b0;
    end else begin
      if (pulse_accept) begin
        gap_cnt <= GW'(1);
      end else if (gap_cnt != GW'(MIN_PULSE_GAP)) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
      if (too_close) begin
        tamper <= 1'b1;
      end
    end
  end

  assign pulse_ok = pulse_accept && !too_close && !tamper;
`else
  assign tamper   = 1'b0 & (MIN_PULSE_GAP < 0);
  assign pulse_ok = pulse_accept;
`endif

  assign unit_done = pulse_ok && enable && (pcnt == PW'(PULSES_PER_UNIT - 1));
  assign day_done  = enable && (dcnt == DW'(CYCLES_PER_DAY - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt        <= '0;
      dcnt        <= '0;
      sensor      <= 1'b0;
      date_1      <= 1'b0;
      units_total <= '0;
    end else begin
      sensor <= unit_done;
      date_1 <= day_done;
      if (pulse_ok && enable) begin
        pcnt <= unit_done ? '0 : pcnt + PW'(1);
      end
      if (enable) begin
        dcnt <= day_done ? '0 : dcnt + DW'(1);
      end
      // Strobe keeps firing at saturation; only the total holds.
      if (unit_done && (units_total != UNIT_W'(UNITS_MAX))) begin
        units_total <= units_total + UNIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_meter_pulse_frontend.sv
// Scoreboard bench for meter_pulse_frontend: edge-indexed reference model queues expected strobes,
// a negedge monitor pops and compares them and checks units_total/tamper every cycle.
module tb_meter_pulse_frontend;
  import meter_pkg::*;

`ifdef METER_TAMPER_DETECT_EN
  localparam int  D    = 1;
  localparam int  G    = 8;
  localparam bit  TAMP = 1'b1;
`else
  localparam int  D    = 3;
  localparam int  G    = 2;
  localparam bit  TAMP = 1'b0;
`endif
  localparam int P    = 4;
  localparam int C    = 100;
  localparam int NMAX = 60000;

  logic              clk;
  logic              reset;
  logic              sensor_raw;
  logic              enable;
  logic              sensor;
  logic              date_1;
  logic [UNIT_W-1:0] units_total;
  logic              tamper;

  meter_pulse_frontend #(
    .PULSES_PER_UNIT(P),
    .DEBOUNCE_CYCLES(D),
    .CYCLES_PER_DAY (C),
    .MIN_PULSE_GAP  (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_raw (sensor_raw),
    .enable     (enable),
    .sensor     (sensor),
    .date_1     (date_1),
    .units_total(units_total),
    .tamper     (tamper)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int edge_n;
    int units;
  } sev_t;

  sev_t sq[$];
  int   dq[$];

  // Per-edge history and expectations.
  bit          raw_h[NMAX];
  bit          rst_h[NMAX];
  bit          smp_h[NMAX];
  bit          acc_h[NMAX];
  logic [9:0]  exp_units_h[NMAX];
  bit          exp_tamp_h[NMAX];

  // Reference model state.
  bit stable_m;
  int last_rst   = 0;
  int npulse     = 0;
  int nstrobe    = 0;
  int nen        = 0;
  bit tamp_m     = 1'b0;
  int prev_acc   = -1000000;
  int last_s     = -1;
  int ncoinc     = 0;
  int obs_coinc  = 0;

  int n_vec  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  task automatic report(input string name, input int act, input int exp);
    n_fail++;
    $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  // Model of edge n: debounced level follows the synced raw line once D consecutive samples
  // after the last reset disagree with it; rising flips are consumed two edges later.
  task automatic model_edge(input int n, input bit r, input bit raw, input bit en);
    bit flip;
    raw_h[n] = raw;
    rst_h[n] = r;
    if (r) begin
      stable_m = 1'b0;
      last_rst = n;
      npulse   = 0;
      nstrobe  = 0;
      nen      = 0;
      tamp_m   = 1'b0;
      prev_acc = -1000000;
      smp_h[n] = 1'b0;
      acc_h[n] = 1'b0;
    end else begin
      smp_h[n] = (n >= 3) && raw_h[n-2] && !rst_h[n-1] && !rst_h[n-2];
      flip = (n - D >= last_rst);
      if (flip) begin
        for (int j = 0; j < D; j++) begin
          if (smp_h[n-j] == stable_m) flip = 1'b0;
        end
      end
      acc_h[n] = flip && !stable_m;
      if (flip) stable_m = !stable_m;
      if (n >= 3 && acc_h[n-2] && !rst_h[n-1]) begin
        if (TAMP) begin
          if (n - prev_acc < G) tamp_m = 1'b1;
          prev_acc = n;
        end
        if (!tamp_m && en) begin
          npulse++;
          if (npulse % P == 0) begin
            nstrobe++;
            sq.push_back('{n, (nstrobe > UNITS_MAX) ? UNITS_MAX : nstrobe});
            last_s = n;
          end
        end
      end
      if (en) begin
        nen++;
        if (nen % C == 0) begin
          dq.push_back(n);
          if (last_s == n) ncoinc++;
        end
      end
    end
    exp_units_h[n] = 10'((nstrobe > UNITS_MAX) ? UNITS_MAX : nstrobe);
    exp_tamp_h[n]  = tamp_m;
  endtask

  task automatic step(input bit r, input bit raw, input bit en);
    int n;
    @(negedge clk);
    reset      = !r;
    sensor_raw = raw;
    enable     = en;
    n = cyc + 1;
    if (n >= NMAX) begin
      n_fail++;
      $display("FAIL cycle_budget: got %0d expected below %0d", n, NMAX);
      $fatal(1, "cycle budget exceeded");
    end
    model_edge(n, r, raw, en);
  endtask

  task automatic pulse(input int hi, input int lo, input bit en);
    repeat (hi) step(1'b0, 1'b1, en);
    repeat (lo) step(1'b0, 1'b0, en);
  endtask

  task automatic idle(input int n, input bit en);
    repeat (n) step(1'b0, 1'b0, en);
  endtask

  // Monitor: outputs after edge cyc are compared against the model entries for that edge.
  sev_t e;
  always @(negedge clk) begin
    if (cyc >= 1 && !done) begin
      n_vec++;
      if (units_total !== exp_units_h[cyc]) report("units_total", int'(units_total), int'(exp_units_h[cyc]));
      n_vec++;
      if (tamper !== exp_tamp_h[cyc]) report("tamper", int'(tamper), int'(exp_tamp_h[cyc]));
      if (sensor === 1'b1) begin
        n_vec++;
        if (sq.size() == 0) begin
          report("sensor_unexpected", cyc, -1);
        end else begin
          e = sq.pop_front();
          if (e.edge_n != cyc) report("sensor_edge", cyc, e.edge_n);
          else if (units_total !== 10'(e.units)) report("sensor_units", int'(units_total), e.units);
        end
      end
      if (sq.size() > 0 && sq[0].edge_n < cyc) begin
        n_vec++;
        report("sensor_missed", cyc, sq[0].edge_n);
        void'(sq.pop_front());
      end
      if (date_1 === 1'b1) begin
        n_vec++;
        if (dq.size() == 0) report("date_unexpected", cyc, -1);
        else if (dq.pop_front() != cyc) report("date_edge", cyc, -1);
      end
      if (dq.size() > 0 && dq[0] < cyc) begin
        n_vec++;
        report("date_missed", cyc, dq[0]);
        void'(dq.pop_front());
      end
      if (sensor === 1'b1 && date_1 === 1'b1) obs_coinc++;
    end
  end

  initial begin
    reset      = 1'b0;
    sensor_raw = 1'b0;
    enable     = 1'b1;

    // Reset with the raw line toggling, then run past the first day tick.
    for (int i = 0; i < 3; i++) step(1'b1, i[0], 1'b1);
    idle(120, 1'b1);

    // Clean pulses: 8 pulses -> 2 units.
    repeat (8) pulse(6, 6, 1'b1);
    idle(20, 1'b1);

    // Short glitches.
    repeat (10) pulse(2, 6, 1'b1);

    // Enable gating mid-day with pulses applied.
    repeat (2) pulse(6, 6, 1'b1);
    repeat (4) pulse(6, 6, 1'b0);
    idle(2, 1'b0);
    idle(150, 1'b1);

    // Saturation, then unit completions aligned with day ticks.
    repeat (2) step(1'b1, 1'b0, 1'b1);
    repeat (4092) pulse(4, 4, 1'b1);
    for (int u = 0; u < 3; u++) begin
      repeat (3) pulse(4, 4, 1'b1);
      while ((nen + 4 + D) % C != 0) step(1'b0, 1'b0, 1'b1);
      pulse(4, 4, 1'b1);
    end
    idle(10, 1'b1);

    // Randomized run lengths and enable.
    repeat (2) step(1'b1, 1'b0, 1'b1);
    repeat (1500) begin
      pulse($urandom_range(1, 7), $urandom_range(1, 7), ($urandom_range(0, 7) != 0));
    end

    // Close pulse pair, follow-up pulses, reset, clean pulses.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    pulse(2, 3, 1'b1);
    pulse(2, 10, 1'b1);
    repeat (4) pulse(6, 6, 1'b1);
    idle(10, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b1);
    repeat (4) pulse(6, 6, 1'b1);
    idle(20, 1'b0);

    @(negedge clk);
    #1;
    done = 1'b1;
    n_vec++;
    if (sq.size() != 0) report("sensor_pending", sq.size(), 0);
    n_vec++;
    if (dq.size() != 0) report("date_pending", dq.size(), 0);
    n_vec++;
    if (obs_coinc != ncoinc) report("coincident_strobes", obs_coinc, ncoinc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/meter_pulse_frontend.md
# meter_pulse_frontend

- Upstream front-end of the prepaid energy meter. Turns the raw, asynchronous meter-sensor line into clean, debounced consumption strobes, one per billed unit.
- Also generates the day tick that advances the billing date.
- Outputs `sensor` and `date_1` drive the identically named inputs of the `main` billing block directly; each strobe is one cycle high, so `main` sees exactly one rising edge per unit or day.

## Interface
- `PULSES_PER_UNIT`, 4: accepted meter pulses per billed unit (≥1).
- `DEBOUNCE_CYCLES`, 3: consecutive equal synchronized samples required to accept a level change (≥1).
- `CYCLES_PER_DAY`, 100: enabled clock cycles per day tick (≥2).
- `MIN_PULSE_GAP`, 2: minimum cycles between accepted pulses; tamper build only.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `sensor_raw` in 1: raw asynchronous meter pulse line.
- `enable` in 1: metering enable; low freezes the prescaler and day counter.
- `sensor` out 1: one-cycle strobe per completed unit.
- `date_1` out 1: one-cycle day strobe.
- `units_total` out 10: units emitted since reset, saturating at 1023.
- `tamper` out 1: sticky tamper flag.

## Operation
- **Synchronizer:** two flops on `sensor_raw`.
- **Debouncer:**
  - Tracks a stable level and a run counter of samples that differ from it.
  - The counter restarts whenever a sample agrees with the stable level.
  - After `DEBOUNCE_CYCLES` consecutive differing samples, the stable level flips.
  - A 0→1 flip is one accepted pulse. The debouncer runs regardless of `enable`.
- **Prescaler:** `pcnt` counts 0..`PULSES_PER_UNIT`-1 on accepted pulses while `enable`=1.
  - A pulse arriving at `pcnt`=`PULSES_PER_UNIT`-1 sets `sensor`=1 for the next cycle, clears `pcnt`, and increments `units_total` (saturating at 1023).
  - Accepted pulses while `enable`=0 are dropped.
- **Day generator:** `dcnt` counts 0..`CYCLES_PER_DAY`-1 on each `enable`=1 cycle.
  - At terminal count: `date_1`=1 for the next cycle and `dcnt` wraps to 0.
  - `enable`=0 holds `dcnt`.
- **Simultaneous strobes:** `sensor` and `date_1` may assert in the same cycle; both are driven and neither is delayed.
- **Reset values:** when `reset`=0 at an edge:
  - `sensor`=0, `date_1`=0, `units_total`=0, `tamper`=0.
  - `pcnt`=0, `dcnt`=0, stable level=0, sync flops=0.
  - Reset mid-unit discards the partial `pcnt`.
- **Saturation:** at 1023, `sensor` still strobes; only the counter holds.

## Timing
- **Pulse acceptance:** `sensor_raw` is first sampled high at edge k. The pulse is accepted at edge k+2+`DEBOUNCE_CYCLES`.
- **Unit strobe:** on a unit-completing pulse, `sensor` is high in the cycle after edge k+3+`DEBOUNCE_CYCLES`. All outputs are registered.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles is rejected.
- **Day strobe spacing:** with `enable` held high, `date_1` is high exactly once every `CYCLES_PER_DAY` cycles. The first strobe comes `CYCLES_PER_DAY` cycles after reset release.
- **Strobe width:** no strobe lasts more than one cycle.

## Configuration
- `METER_TAMPER_DETECT_EN` defined:
  - A gap counter measures cycles since the last accepted pulse.
  - An accepted pulse fewer than `MIN_PULSE_GAP` cycles after the previous one sets `tamper`=1 and is discarded.
  - While `tamper`=1, all pulses are discarded and `date_1` keeps running.
  - `tamper` clears only on reset.
- `METER_TAMPER_DETECT_EN` undefined:
  - No gap counter; `tamper` is tied to 0.
  - `MIN_PULSE_GAP` is unused, and every accepted pulse reaches the prescaler.

## Structure
- **Package `meter_pkg`:**
  - `UNIT_W`=10 and `UNITS_MAX`=1023.
  - Default values for `PULSES_PER_UNIT`, `DEBOUNCE_CYCLES`, `CYCLES_PER_DAY`, `MIN_PULSE_GAP`.
  - Shared with `main`.
- **Sub-module `meter_debounce`:**
  - Contains the synchronizer plus the debouncer, parameterized by `DEBOUNCE_CYCLES`.
  - Outputs a one-cycle `pulse_accept`.
- **Top level:** the prescaler, day counter, totals and tamper logic stay in the top.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `sensor_raw` toggling → all outputs 0. Release; after 100 cycles → `date_1` high exactly 1 cycle.
- **Unit counting:** 8 clean raw pulses, 6 cycles high / 6 low, defaults, `enable`=1 → exactly 2 `sensor` strobes, `units_total`=2. The first strobe comes 6 cycles after the 4th pulse's rising sample.
- **Glitch rejection:** 2-cycle raw glitches ×10 → no accepted pulses, `units_total`=0, `pcnt` unchanged.
- **Enable gating:** `enable`=0 for 50 cycles mid-day with pulses applied → no strobes. After re-enable, `date_1` fires 100 enabled cycles after the previous tick.
- **Saturation and coincidence:** preload to 1023 via 4092 pulses → `units_total` holds 1023 and `sensor` still strobes. Align the completing pulse with terminal `dcnt` → `sensor` and `date_1` high in the same cycle.
- **Tamper (macro on, `DEBOUNCE_CYCLES`=1):** `MIN_PULSE_GAP`=8, two pulses 5 cycles apart → `tamper`=1 on the second pulse and no further `sensor` strobes. Only reset clears `tamper`.
